// File: rtl/ddr2_cmd_mon.sv
// DDR2 command-bus monitor: decodes controller commands, follows the JEDEC
// power-up sequence and flags sequence, timing and bank-state violations.
`timescale 1ns/1ps
module ddr2_cmd_mon #(
    parameter int BA_BITS   = 3,
    parameter int ADDR_BITS = 13,
    parameter int T_RP      = 4,
    parameter int T_RFC     = 52,
    parameter int T_MRD     = 2,
    parameter int T_RCD     = 4
) (
    input  logic                      ck,
    input  logic                      rst_n,
    input  logic                      ddr2_cke,
    input  logic                      ddr2_cs_n,
    input  logic                      ddr2_ras_n,
    input  logic                      ddr2_cas_n,
    input  logic                      ddr2_we_n,
    input  logic [BA_BITS-1:0]        ddr2_ba,
    input  logic [ADDR_BITS-1:0]      ddr2_addr,
    output logic                      cmd_vld,
    output logic [3:0]                cmd_code,
    output logic                      init_done,
    output logic [ADDR_BITS-1:0]      mr_reg,
    output logic [ADDR_BITS-1:0]      emr1_reg,
    output logic [(1<<BA_BITS)-1:0]   bank_open,
    output logic [15:0]               aref_cnt,
    output logic                      err_seq,
    output logic                      err_timing,
    output logic                      err_state
);
    localparam int NB    = 1 << BA_BITS;
    localparam int T_MAX = (T_RFC > T_RP) ? ((T_RFC > T_MRD) ? T_RFC : T_MRD)
                                          : ((T_RP > T_MRD) ? T_RP : T_MRD);
    localparam int CNT_W = $clog2(T_MAX + 1);
    localparam int RCD_W = (T_RCD > 1) ? $clog2(T_RCD + 1) : 1;

    localparam logic [3:0] C_MRS  = 4'b0000;
    localparam logic [3:0] C_AREF = 4'b0001;
    localparam logic [3:0] C_PRE  = 4'b0010;
    localparam logic [3:0] C_ACT  = 4'b0011;
    localparam logic [3:0] C_WR   = 4'b0100;
    localparam logic [3:0] C_RD   = 4'b0101;
    localparam logic [3:0] C_NOP  = 4'b0111;

    typedef enum logic [3:0] {
        I_CKE   = 4'd0,
        I_PREA1 = 4'd1,
        I_EMR2  = 4'd2,
        I_EMR3  = 4'd3,
        I_EMR1  = 4'd4,
        I_MR1   = 4'd5,
        I_PREA2 = 4'd6,
        I_REF1  = 4'd7,
        I_REF2  = 4'd8,
        I_MR2   = 4'd9,
        I_DONE  = 4'd10
    } init_state_t;

    // ---------------- command decode (combinational on sampled pins)
    logic [3:0]      w_cmd;
    logic            w_sel;
    logic            w_vld;
    logic            w_act, w_rd, w_wr, w_pre, w_aref, w_mrs;
    logic            w_timed;
    logic            w_a10;
    logic            w_busy;
    logic            w_any_open;
    logic            w_tim_err;
    logic            w_st_err;
    logic            w_step_ok;
    logic [NB-1:0]   w_rcd_busy;
    logic [NB-1:0]   w_bank_open;

    assign w_cmd   = {ddr2_cs_n, ddr2_ras_n, ddr2_cas_n, ddr2_we_n};
    assign w_sel   = ddr2_cke & ~ddr2_cs_n;
    assign w_vld   = w_sel & (w_cmd != C_NOP);
    assign w_act   = w_sel & (w_cmd == C_ACT);
    assign w_rd    = w_sel & (w_cmd == C_RD);
    assign w_wr    = w_sel & (w_cmd == C_WR);
    assign w_pre   = w_sel & (w_cmd == C_PRE);
    assign w_aref  = w_sel & (w_cmd == C_AREF);
    assign w_mrs   = w_sel & (w_cmd == C_MRS);
    // BST and other undefined patterns take no part in timing or bank checks
    assign w_timed = w_act | w_rd | w_wr | w_pre | w_aref | w_mrs;
    assign w_a10   = ddr2_addr[10];

    // ---------------- registers
    logic [CNT_W-1:0]      r_busy;
    init_state_t           r_state;
    logic                  r_init_done;
    logic                  r_cmd_vld;
    logic [3:0]            r_cmd_code;
    logic [ADDR_BITS-1:0]  r_mr;
    logic [ADDR_BITS-1:0]  r_emr1;
    logic [15:0]           r_aref_cnt;
    logic                  r_err_seq;
    logic                  r_err_timing;
    logic                  r_err_state;

    assign w_busy     = (r_busy != '0);
    assign w_any_open = |w_bank_open;

    assign w_tim_err = (w_timed & w_busy)
                     | ((w_rd | w_wr) & w_rcd_busy[ddr2_ba]);

    assign w_st_err  = (w_act & w_bank_open[ddr2_ba])
                     | ((w_rd | w_wr) & ~w_bank_open[ddr2_ba])
                     | ((w_aref | w_mrs) & w_any_open);

    always_comb begin
        w_step_ok = 1'b0;
        case (r_state)
            I_PREA1, I_PREA2: w_step_ok = w_pre & w_a10;
            I_EMR2:           w_step_ok = w_mrs & (ddr2_ba == BA_BITS'(2));
            I_EMR3:           w_step_ok = w_mrs & (ddr2_ba == BA_BITS'(3));
            I_EMR1:           w_step_ok = w_mrs & (ddr2_ba == BA_BITS'(1));
            I_MR1, I_MR2:     w_step_ok = w_mrs & (ddr2_ba == BA_BITS'(0));
            I_REF1, I_REF2:   w_step_ok = w_aref;
            default:          w_step_ok = 1'b0;
        endcase
    end

    // ---------------- init sequence FSM
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= I_CKE;
            r_init_done <= 1'b0;
            r_err_seq   <= 1'b0;
        end else begin
            case (r_state)
                I_CKE: begin
                    if (ddr2_cke)
                        r_state <= I_PREA1;
                    if (w_vld)
                        r_err_seq <= 1'b1;
                end
                I_DONE: r_init_done <= 1'b1;
                I_PREA1, I_EMR2, I_EMR3, I_EMR1, I_MR1,
                I_PREA2, I_REF1, I_REF2, I_MR2: begin
                    if (w_vld) begin
                        if (w_step_ok) begin
                            r_state <= init_state_t'(r_state + 4'd1);
                            if (r_state == I_MR2)
                                r_init_done <= 1'b1;
                        end else begin
                            r_err_seq <= 1'b1;
                        end
                    end
                end
                default: r_state <= I_CKE;
            endcase
        end
    end

    // ---------------- shared busy counter (tRP / tRFC / tMRD)
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n)
            r_busy <= '0;
        else if (w_pre)
            r_busy <= CNT_W'(T_RP - 1);
        else if (w_aref)
            r_busy <= CNT_W'(T_RFC - 1);
        else if (w_mrs)
            r_busy <= CNT_W'(T_MRD - 1);
        else if (w_busy)
            r_busy <= r_busy - CNT_W'(1);
    end

    // ---------------- per-bank tRCD counter and open-row state
    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_bank
            logic [RCD_W-1:0] r_rcd;
            logic             r_open;
            logic             w_hit;

            assign w_hit = (ddr2_ba == BA_BITS'(gi));

            always_ff @(posedge ck or negedge rst_n) begin
                if (!rst_n)
                    r_rcd <= '0;
                else if (w_act && w_hit)
                    r_rcd <= RCD_W'(T_RCD - 1);
                else if (r_rcd != '0)
                    r_rcd <= r_rcd - RCD_W'(1);
            end

            always_ff @(posedge ck or negedge rst_n) begin
                if (!rst_n)
                    r_open <= 1'b0;
                else if (w_act && w_hit)
                    r_open <= 1'b1;
                else if (w_pre && (w_a10 || w_hit))
                    r_open <= 1'b0;
            end

            assign w_rcd_busy[gi]  = (r_rcd != '0);
            assign w_bank_open[gi] = r_open;
        end
    endgenerate

    // ---------------- decoded-command outputs, mode registers, refresh count
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd_vld  <= 1'b0;
            r_cmd_code <= 4'd0;
            r_mr       <= '0;
            r_emr1     <= '0;
            r_aref_cnt <= 16'd0;
        end else begin
            r_cmd_vld <= w_vld;
            if (w_vld)
                r_cmd_code <= w_cmd;
            if (w_mrs && ddr2_ba == BA_BITS'(0))
                r_mr <= ddr2_addr;
            if (w_mrs && ddr2_ba == BA_BITS'(1))
                r_emr1 <= ddr2_addr;
            if (w_aref && r_init_done && r_aref_cnt != 16'hFFFF)
                r_aref_cnt <= r_aref_cnt + 16'd1;
        end
    end

    // ---------------- sticky error flags
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            r_err_timing <= 1'b0;
            r_err_state  <= 1'b0;
        end else begin
            if (w_tim_err)
                r_err_timing <= 1'b1;
            if (w_st_err)
                r_err_state <= 1'b1;
        end
    end

    assign cmd_vld    = r_cmd_vld;
    assign cmd_code   = r_cmd_code;
    assign init_done  = r_init_done;
    assign mr_reg     = r_mr;
    assign emr1_reg   = r_emr1;
    assign bank_open  = w_bank_open;
    assign aref_cnt   = r_aref_cnt;
    assign err_seq    = r_err_seq;
    assign err_timing = r_err_timing;
    assign err_state  = r_err_state;

endmodule

// File: tb/tb_ddr2_cmd_mon.sv
// Scoreboard bench for ddr2_cmd_mon: a cycle-time reference model predicts the
// full output state after every decoded command; a monitor checks each cmd_vld.
`timescale 1ns/1ps
module tb_ddr2_cmd_mon;
    localparam int BA_BITS = 3, ADDR_BITS = 13;
    localparam int T_RP = 4, T_RFC = 52, T_MRD = 2, T_RCD = 4;
    localparam int NB = 8;

    localparam logic [3:0] C_MRS  = 4'b0000;
    localparam logic [3:0] C_AREF = 4'b0001;
    localparam logic [3:0] C_PRE  = 4'b0010;
    localparam logic [3:0] C_ACT  = 4'b0011;
    localparam logic [3:0] C_WR   = 4'b0100;
    localparam logic [3:0] C_RD   = 4'b0101;
    localparam logic [3:0] C_BST  = 4'b0110;
    localparam logic [3:0] C_NOP  = 4'b0111;

    logic        ck = 1'b0;
    logic        rst_n = 1'b0;
    logic        cke = 1'b0, cs_n = 1'b1, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
    logic [2:0]  ba = '0;
    logic [12:0] addr = '0;

    logic        cmd_vld;
    logic [3:0]  cmd_code;
    logic        init_done;
    logic [12:0] mr_reg, emr1_reg;
    logic [7:0]  bank_open;
    logic [15:0] aref_cnt;
    logic        err_seq, err_timing, err_state;

    ddr2_cmd_mon #(
        .BA_BITS(BA_BITS), .ADDR_BITS(ADDR_BITS),
        .T_RP(T_RP), .T_RFC(T_RFC), .T_MRD(T_MRD), .T_RCD(T_RCD)
    ) dut (
        .ck(ck), .rst_n(rst_n), .ddr2_cke(cke), .ddr2_cs_n(cs_n),
        .ddr2_ras_n(ras_n), .ddr2_cas_n(cas_n), .ddr2_we_n(we_n),
        .ddr2_ba(ba), .ddr2_addr(addr),
        .cmd_vld(cmd_vld), .cmd_code(cmd_code), .init_done(init_done),
        .mr_reg(mr_reg), .emr1_reg(emr1_reg), .bank_open(bank_open),
        .aref_cnt(aref_cnt), .err_seq(err_seq), .err_timing(err_timing),
        .err_state(err_state)
    );

    always #5 ck = ~ck;

    typedef struct {
        logic [3:0]  code;
        logic        done;
        logic [12:0] mr;
        logic [12:0] emr1;
        logic [7:0]  open;
        logic [15:0] aref;
        logic        eseq;
        logic        etim;
        logic        est;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   n_aref_pulse = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: absolute cycle numbers, step index
    int          cyc = 0;
    int          m_st;
    int          free_at;
    int          act_at[NB];
    logic [7:0]  m_open;
    logic [12:0] m_mr, m_emr1;
    logic [15:0] m_aref;
    logic        m_eseq, m_etim, m_est;

    task automatic model_reset();
        m_st = 0; free_at = -1000;
        for (int i = 0; i < NB; i++) act_at[i] = -1000;
        m_open = '0; m_mr = '0; m_emr1 = '0; m_aref = '0;
        m_eseq = 0; m_etim = 0; m_est = 0;
    endtask

    task automatic model_step(input logic k, input logic [3:0] code,
                              input logic [2:0] b, input logic [12:0] a);
        bit   vld, done_before, a10, match;
        exp_t e;
        vld = k && !code[3] && code != C_NOP;
        done_before = (m_st == 10);
        a10 = a[10];
        match = 0;
        if (m_st == 0) begin
            if (vld) m_eseq = 1;
            if (k) m_st = 1;
        end else if (vld && m_st < 10) begin
            case (m_st)
                1, 6:    match = (code == C_PRE) && a10;
                2:       match = (code == C_MRS) && b == 3'd2;
                3:       match = (code == C_MRS) && b == 3'd3;
                4:       match = (code == C_MRS) && b == 3'd1;
                5, 9:    match = (code == C_MRS) && b == 3'd0;
                7, 8:    match = (code == C_AREF);
                default: match = 0;
            endcase
            if (match) m_st++;
            else m_eseq = 1;
        end
        if (vld && code != C_BST) begin
            if (cyc < free_at) m_etim = 1;
            if ((code == C_RD || code == C_WR) && cyc < act_at[b] + T_RCD) m_etim = 1;
            case (code)
                C_ACT: begin
                    if (m_open[b]) m_est = 1;
                    m_open[b] = 1'b1;
                    act_at[b] = cyc;
                end
                C_RD, C_WR: if (!m_open[b]) m_est = 1;
                C_PRE: begin
                    if (a10) m_open = '0;
                    else m_open[b] = 1'b0;
                    free_at = cyc + T_RP;
                end
                C_AREF: begin
                    if (m_open != 0) m_est = 1;
                    free_at = cyc + T_RFC;
                    if (done_before && m_aref != 16'hFFFF) m_aref++;
                end
                C_MRS: begin
                    if (m_open != 0) m_est = 1;
                    free_at = cyc + T_MRD;
                    if (b == 3'd0) m_mr = a;
                    else if (b == 3'd1) m_emr1 = a;
                end
                default: ;
            endcase
        end
        if (vld) begin
            e.code = code; e.done = (m_st == 10); e.mr = m_mr; e.emr1 = m_emr1;
            e.open = m_open; e.aref = m_aref;
            e.eseq = m_eseq; e.etim = m_etim; e.est = m_est;
            sb_q.push_back(e);
        end
        cyc++;
    endtask

    // ---------------- monitor
    always @(negedge ck) begin
        exp_t e;
        if (rst_n && (cmd_vld || sb_q.size() != 0)) begin
            if (!cmd_vld) begin
                void'(sb_q.pop_front());
                check("cmd_vld_missing", {31'd0, cmd_vld}, 32'd1);
            end else if (sb_q.size() == 0) begin
                check("cmd_vld_unexpected", {31'd0, cmd_vld}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                $display("txn t=%0t code=%b done=%0d open=%b aref=%0d err=%0d%0d%0d",
                         $time, cmd_code, init_done, bank_open, aref_cnt,
                         err_seq, err_timing, err_state);
                check("cmd_code",   {28'd0, cmd_code},  {28'd0, e.code});
                check("init_done",  {31'd0, init_done}, {31'd0, e.done});
                check("mr_reg",     {19'd0, mr_reg},    {19'd0, e.mr});
                check("emr1_reg",   {19'd0, emr1_reg},  {19'd0, e.emr1});
                check("bank_open",  {24'd0, bank_open}, {24'd0, e.open});
                check("aref_cnt",   {16'd0, aref_cnt},  {16'd0, e.aref});
                check("err_seq",    {31'd0, err_seq},   {31'd0, e.eseq});
                check("err_timing", {31'd0, err_timing},{31'd0, e.etim});
                check("err_state",  {31'd0, err_state}, {31'd0, e.est});
                if (cmd_code == C_AREF) n_aref_pulse++;
            end
        end
    end

    // ---------------- stimulus helpers
    task automatic drive(input logic k, input logic [3:0] code,
                         input logic [2:0] b, input logic [12:0] a);
        @(negedge ck);
        cke = k; {cs_n, ras_n, cas_n, we_n} = code; ba = b; addr = a;
        @(posedge ck);
        model_step(k, code, b, a);
    endtask

    task automatic cmd(input logic [3:0] code, input logic [2:0] b, input logic [12:0] a);
        drive(1'b1, code, b, a);
    endtask

    task automatic nop(input int n);
        repeat (n) drive(1'b1, 4'b1111, 3'd0, 13'd0);
    endtask

    task automatic do_reset();
        nop(2);
        @(negedge ck);
        rst_n = 1'b0;
        cke = 1'b0; {cs_n, ras_n, cas_n, we_n} = 4'b1111; ba = '0; addr = '0;
        model_reset();
        check("sb_empty_at_reset", sb_q.size(), 32'd0);
        sb_q.delete();
        repeat (3) @(negedge ck);
        rst_n = 1'b1;
    endtask

    task automatic check_zero(input string tag);
        #1;
        check({tag, "_outputs"},
              {cmd_vld, cmd_code, init_done, err_seq, err_timing, err_state, bank_open},
              32'd0);
        check({tag, "_regs"}, {3'd0, mr_reg, 3'd0, emr1_reg}, 32'd0);
        check({tag, "_aref"}, {16'd0, aref_cnt}, 32'd0);
    endtask

    task automatic legal_init(input logic [12:0] mr1, input logic [12:0] mr2,
                              input logic [12:0] emr1, input int gap);
        nop(3);
        cmd(C_PRE, 3'd0, 13'h0400); nop(gap);
        cmd(C_MRS, 3'd2, 13'h0000); nop(gap);
        cmd(C_MRS, 3'd3, 13'h0000); nop(gap);
        cmd(C_MRS, 3'd1, emr1);     nop(gap);
        cmd(C_MRS, 3'd0, mr1);      nop(gap);
        cmd(C_PRE, 3'd0, 13'h0400); nop(gap);
        cmd(C_AREF, 3'd0, 13'h0);   nop(gap);
        cmd(C_AREF, 3'd0, 13'h0);   nop(gap);
        cmd(C_MRS, 3'd0, mr2);      nop(gap);
    endtask

    task automatic rand_cmd();
        logic [3:0]  code;
        logic [2:0]  b;
        logic [12:0] a;
        logic        k;
        int          pick;
        pick = $urandom_range(0, 10);
        case (pick)
            0, 1:    code = C_ACT;
            2:       code = C_RD;
            3:       code = C_WR;
            4, 5:    code = C_PRE;
            6:       code = C_AREF;
            7:       code = C_MRS;
            8:       code = C_BST;
            9:       code = C_NOP;
            default: code = 4'($urandom_range(8, 15));
        endcase
        b = 3'($urandom_range(0, 7));
        a = 13'($urandom);
        k = ($urandom_range(0, 7) != 0);
        drive(k, code, b, a);
        nop($urandom_range(0, 5));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        model_reset();
        repeat (3) @(negedge ck);
        check_zero("reset");
        rst_n = 1'b1;

        // legal power-up sequence
        legal_init(13'h0532, 13'h0432, 13'h0044, T_RFC);
        #1;
        check("init_done", {31'd0, init_done}, 32'd1);
        check("mr_after_init", {19'd0, mr_reg}, 32'h0432);
        check("emr1_after_init", {19'd0, emr1_reg}, 32'h0044);
        check("errs_after_init", {29'd0, err_seq, err_timing, err_state}, 32'd0);

        // periodic refresh after init
        base = n_aref_pulse;
        repeat (5) begin
            nop(99);
            cmd(C_AREF, 3'd0, 13'h0);
        end
        nop(2);
        check("aref_cnt_5", {16'd0, aref_cnt}, 32'd5);
        check("aref_pulses_5", n_aref_pulse - base, 32'd5);
        check("errs_after_aref", {29'd0, err_seq, err_timing, err_state}, 32'd0);

        // PRE followed by AREF inside tRP
        nop(T_RFC);
        cmd(C_PRE, 3'd0, 13'h0000);
        nop(1);
        cmd(C_AREF, 3'd0, 13'h0);
        #1;
        check("trp_err_timing", {31'd0, err_timing}, 32'd1);
        check("trp_err_state", {31'd0, err_state}, 32'd0);

        // tRCD violation then read to closed bank
        do_reset();
        legal_init(13'h0532, 13'h0432, 13'h0000, T_RFC);
        cmd(C_ACT, 3'd2, 13'h0123);
        nop(1);
        cmd(C_RD, 3'd2, 13'h0000);
        #1;
        check("trcd_err_timing", {31'd0, err_timing}, 32'd1);
        check("trcd_err_state", {31'd0, err_state}, 32'd0);
        nop(T_RCD);
        cmd(C_RD, 3'd5, 13'h0000);
        #1;
        check("closed_rd_err_state", {31'd0, err_state}, 32'd1);
        check("bank_open_b2", {24'd0, bank_open}, 32'h04);

        // out-of-order command during init
        do_reset();
        nop(3);
        cmd(C_PRE, 3'd0, 13'h0400);  nop(T_RFC);
        cmd(C_AREF, 3'd0, 13'h0);    nop(T_RFC);
        #1;
        check("seq_err_set", {31'd0, err_seq}, 32'd1);
        check("seq_not_done", {31'd0, init_done}, 32'd0);
        cmd(C_MRS, 3'd2, 13'h0);     nop(T_RFC);
        cmd(C_MRS, 3'd3, 13'h0);     nop(T_RFC);
        cmd(C_MRS, 3'd1, 13'h0);     nop(T_RFC);
        cmd(C_MRS, 3'd0, 13'h0532);  nop(T_RFC);
        cmd(C_PRE, 3'd0, 13'h0400);  nop(T_RFC);
        cmd(C_AREF, 3'd0, 13'h0);    nop(T_RFC);
        cmd(C_AREF, 3'd0, 13'h0);    nop(T_RFC);
        cmd(C_MRS, 3'd0, 13'h0432);  nop(2);
        #1;
        check("seq_done_after", {31'd0, init_done}, 32'd1);
        check("seq_err_sticky", {31'd0, err_seq}, 32'd1);

        // reset in the middle of init
        do_reset();
        nop(3);
        cmd(C_PRE, 3'd0, 13'h0400);  nop(T_RFC);
        cmd(C_MRS, 3'd2, 13'h0);     nop(3);
        do_reset();
        @(negedge ck);
        check_zero("midreset");
        legal_init(13'h0532, 13'h0432, 13'h0000, T_RFC);
        #1;
        check("midreset_init_done", {31'd0, init_done}, 32'd1);
        check("midreset_errs", {29'd0, err_seq, err_timing, err_state}, 32'd0);

        // randomized segments, each from a fresh reset
        for (int seg = 0; seg < 6; seg++) begin
            do_reset();
            legal_init(13'($urandom), 13'($urandom), 13'($urandom),
                       (seg < 3) ? T_RFC : $urandom_range(0, 60));
            for (int n = 0; n < 150; n++) rand_cmd();
        end

        nop(3);
        check("sb_drained", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
